// File: rtl/sync_edge_filter_pkg.sv
// Shared definitions for the multi-channel synchroniser: edge-mode encodings,
// default parameters and the pulse decode helper used by every channel.
package sync_edge_filter_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edgeMode_e;

    localparam int DEFAULT_NR_CHANNELS   = 8;
    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_FILTER_CYCLES = 4;

    // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
    function automatic logic decodePulse(input logic level, input logic levelD,
                                         input logic [1:0] mode);
        return (level & ~levelD & mode[0]) | (~level & levelD & mode[1]);
    endfunction

endpackage

// File: rtl/sync_edge_channel.sv
// One synchroniser channel: metastability chain, optional glitch filter,
// registered level with delayed copy for edge decode, and a sticky event bit.
module sync_edge_channel
    import sync_edge_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       i_asyncIn,
    input  logic       i_filterEnable,
    input  logic [1:0] i_edgeMode,
    input  logic       i_clearFlag,
    output logic       o_levelOut,
    output logic       o_pulseOut,
    output logic       o_stickyFlag
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_badSyncStages
        $error("sync_edge_channel: SYNC_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_badFilterCycles
        $error("sync_edge_channel: FILTER_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_levelD;
    logic                   r_sticky;
    logic                   w_sync;
    logic                   w_pulse;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_asyncIn};
        end
    end

    // The level only moves once the synchronised value has disagreed with it
    // for FILTER_CYCLES consecutive edges; disabling the filter drops any count.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (!i_filterEnable) begin
            r_level <= w_sync;
            r_cnt   <= '0;
        end else if (w_sync == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= w_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_pulse = decodePulse(r_level, r_levelD, i_edgeMode);

    // A new event outranks a simultaneous software clear.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_levelD <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_levelD <= r_level;
            r_sticky <= (r_sticky & ~i_clearFlag) | w_pulse;
        end
    end

    assign o_levelOut   = r_level;
    assign o_pulseOut   = w_pulse;
    assign o_stickyFlag = r_sticky;

endmodule

// File: rtl/sync_edge_filter.sv
// Multi-channel synchroniser top: slices the buses into independent channels
// and ORs the sticky flags into a single interrupt.
module sync_edge_filter
    import sync_edge_filter_pkg::*;
#(
    parameter int NR_CHANNELS   = DEFAULT_NR_CHANNELS,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic [NR_CHANNELS-1:0]   asyncIn,
    input  logic                     filterEnable,
    input  logic [2*NR_CHANNELS-1:0] edgeMode,
    input  logic [NR_CHANNELS-1:0]   clearFlags,
    output logic [NR_CHANNELS-1:0]   levelOut,
    output logic [NR_CHANNELS-1:0]   pulseOut,
    output logic [NR_CHANNELS-1:0]   stickyFlags,
    output logic                     irq
);

    if (NR_CHANNELS < 1) begin : g_badChannels
        $error("sync_edge_filter: NR_CHANNELS must be at least 1");
    end

    for (genvar i = 0; i < NR_CHANNELS; i++) begin : g_channel
        sync_edge_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_channel (
            .clock          (clock),
            .resetN         (resetN),
            .i_asyncIn      (asyncIn[i]),
            .i_filterEnable (filterEnable),
            .i_edgeMode     (edgeMode[2*i+1:2*i]),
            .i_clearFlag    (clearFlags[i]),
            .o_levelOut     (levelOut[i]),
            .o_pulseOut     (pulseOut[i]),
            .o_stickyFlag   (stickyFlags[i])
        );
    end

    assign irq = |stickyFlags;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed self-checking bench for sync_edge_filter with default parameters;
// expected values are hand-derived edge counts from asyncIn changes.
module tb_sync_edge_filter;
    import sync_edge_filter_pkg::*;

    logic        clock;
    logic        resetN;
    logic [7:0]  asyncIn;
    logic        filterEnable;
    logic [15:0] edgeMode;
    logic [7:0]  clearFlags;
    logic [7:0]  levelOut;
    logic [7:0]  pulseOut;
    logic [7:0]  stickyFlags;
    logic        irq;

    int checkCount = 0;
    int errorCount = 0;

    sync_edge_filter dut (
        .clock        (clock),
        .resetN       (resetN),
        .asyncIn      (asyncIn),
        .filterEnable (filterEnable),
        .edgeMode     (edgeMode),
        .clearFlags   (clearFlags),
        .levelOut     (levelOut),
        .pulseOut     (pulseOut),
        .stickyFlags  (stickyFlags),
        .irq          (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic [7:0] a, input logic f,
                                 input logic [15:0] m, input logic [7:0] c);
        asyncIn      = a;
        filterEnable = f;
        edgeMode     = m;
        clearFlags   = c;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic stepEdges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic seen;
        int   p3Count;
        int   p4Count;
        int   p3First;
        int   p3Second;
        logic [15:0] modeT3;

        // Test 1: all inputs high through reset, then release.
        resetN = 1'b0;
        applyStimulus(8'hFF, 1'b0, 16'h5555, 8'h00);
        stepEdges(3);
        checkOutput("rst_level", 16'(levelOut), 16'h00);
        checkOutput("rst_pulse", 16'(pulseOut), 16'h00);
        checkOutput("rst_sticky", 16'(stickyFlags), 16'h00);
        checkOutput("rst_irq", 16'(irq), 16'h0);
        resetN = 1'b1;
        stepEdges(2);
        checkOutput("t1_level_e2", 16'(levelOut), 16'h00);
        stepEdges(1);
        checkOutput("t1_level_e3", 16'(levelOut), 16'hFF);
        checkOutput("t1_pulse_e3", 16'(pulseOut), 16'hFF);
        stepEdges(1);
        checkOutput("t1_pulse_e4", 16'(pulseOut), 16'h00);
        checkOutput("t1_sticky", 16'(stickyFlags), 16'hFF);
        checkOutput("t1_irq", 16'(irq), 16'h1);
        applyStimulus(8'hFF, 1'b0, 16'h5555, 8'hFF);
        stepEdges(1);
        checkOutput("t1_clear_all", 16'(stickyFlags), 16'h00);
        checkOutput("t1_irq_clr", 16'(irq), 16'h0);
        applyStimulus(8'h00, 1'b0, 16'h5555, 8'h00);
        stepEdges(5);
        checkOutput("t1_fall_level", 16'(levelOut), 16'h00);
        checkOutput("t1_fall_nopulse", 16'(stickyFlags), 16'h00);

        // Test 2: filter on, 3-cycle glitch then 4+ cycle pulse on ch0.
        applyStimulus(8'h01, 1'b1, 16'h5555, 8'h00);
        stepEdges(3);
        asyncIn = 8'h00;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            stepEdges(1);
            seen = seen | levelOut[0] | pulseOut[0];
        end
        checkOutput("t2_glitch", 16'(seen), 16'h0);
        asyncIn = 8'h01;
        stepEdges(5);
        checkOutput("t2_level_e5", 16'(levelOut[0]), 16'h0);
        stepEdges(1);
        checkOutput("t2_level_e6", 16'(levelOut[0]), 16'h1);
        checkOutput("t2_pulse_e6", 16'(pulseOut), 16'h01);
        stepEdges(1);
        checkOutput("t2_pulse_e7", 16'(pulseOut[0]), 16'h0);
        checkOutput("t2_sticky", 16'(stickyFlags), 16'h01);
        asyncIn = 8'h00;
        stepEdges(8);
        checkOutput("t2_filtered_fall", 16'(levelOut[0]), 16'h0);
        clearFlags = 8'hFF;
        stepEdges(1);
        clearFlags = 8'h00;
        checkOutput("t2_cleared", 16'(stickyFlags), 16'h00);

        // Test 3: filter off, ch3 both edges, ch4 mode none, 10 cycles high.
        modeT3 = 16'h5555;
        modeT3[7:6] = EDGE_BOTH;
        modeT3[9:8] = EDGE_NONE;
        applyStimulus(8'h18, 1'b0, modeT3, 8'h00);
        p3Count = 0; p4Count = 0; p3First = -1; p3Second = -1;
        for (int k = 1; k <= 20; k++) begin
            stepEdges(1);
            if (pulseOut[3]) begin
                p3Count++;
                if (p3First < 0) p3First = k;
                else if (p3Second < 0) p3Second = k;
            end
            if (pulseOut[4]) p4Count++;
            if (k == 10) asyncIn = 8'h00;
        end
        checkOutput("t3_p3_count", 16'(p3Count), 16'd2);
        checkOutput("t3_p3_first", 16'(p3First), 16'd3);
        checkOutput("t3_p3_second", 16'(p3Second), 16'd13);
        checkOutput("t3_p4_none", 16'(p4Count), 16'd0);
        checkOutput("t3_sticky", 16'(stickyFlags), 16'h08);

        // Test 4: clear coincident with a pulse, then a plain clear.
        asyncIn = 8'h08;
        stepEdges(3);
        checkOutput("t4_pulse", 16'(pulseOut), 16'h08);
        clearFlags = 8'h08;
        stepEdges(1);
        checkOutput("t4_set_wins", 16'(stickyFlags[3]), 16'h1);
        stepEdges(1);
        checkOutput("t4_cleared", 16'(stickyFlags), 16'h00);
        checkOutput("t4_irq", 16'(irq), 16'h0);
        clearFlags = 8'h00;

        // Test 5: filter on, ch1 mid-count, async reset between edges.
        applyStimulus(8'h0A, 1'b1, modeT3, 8'h00);
        stepEdges(4);
        checkOutput("t5_cnt_before", 16'(dut.g_channel[1].u_channel.r_cnt), 16'd2);
        asyncIn = 8'h08;
        #1 resetN = 1'b0;
        #1;
        checkOutput("t5_rst_level", 16'(levelOut), 16'h00);
        checkOutput("t5_rst_pulse", 16'(pulseOut), 16'h00);
        checkOutput("t5_rst_sticky", 16'(stickyFlags), 16'h00);
        checkOutput("t5_rst_irq", 16'(irq), 16'h0);
        checkOutput("t5_rst_cnt", 16'(dut.g_channel[1].u_channel.r_cnt), 16'd0);
        #1 resetN = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            stepEdges(1);
            seen = seen | levelOut[1] | pulseOut[1];
        end
        checkOutput("t5_ch1_quiet", 16'(seen), 16'h0);
        checkOutput("t5_ch3_rise", 16'(stickyFlags), 16'h08);

        // Test 6: filter dropped while ch2 is mid-count.
        asyncIn = 8'h0C;
        stepEdges(4);
        checkOutput("t6_cnt_before", 16'(dut.g_channel[2].u_channel.r_cnt), 16'd2);
        checkOutput("t6_level_before", 16'(levelOut[2]), 16'h0);
        filterEnable = 1'b0;
        stepEdges(1);
        checkOutput("t6_level_after", 16'(levelOut[2]), 16'h1);
        checkOutput("t6_pulse_after", 16'(pulseOut), 16'h04);
        checkOutput("t6_cnt_after", 16'(dut.g_channel[2].u_channel.r_cnt), 16'd0);
        stepEdges(1);
        checkOutput("t6_pulse_once", 16'(pulseOut[2]), 16'h0);
        checkOutput("t6_sticky", 16'(stickyFlags), 16'h0C);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
